// File: rtl/wb_pkg.sv
// Shared constants and helpers for the writeback arbiter and its tag FIFO.
package wb_pkg;
  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         NUM_REGS     = 32;
  localparam int         DEF_DW       = 32;
  localparam int         DEF_LD_DEPTH = 4;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [4:0] r);
    logic [NUM_REGS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/wb_tag_fifo.sv
// In-order FIFO of load destination tags with an occupancy vector for the
// pending-write scoreboard. Push/pop legality is decided by the instantiating logic.
module wb_tag_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEF_LD_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [4:0]          tag_i,
  output logic [4:0]          tag_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [NUM_REGS-1:0] occ_o
);
  logic [4:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= REG_ZERO;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= tag_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Only entries between the read pointer and read pointer + count are live.
  always_comb begin
    occ_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) occ_o = occ_o | reg_onehot(mem_q[rd_ptr_q + PW'(i)]);
    end
  end

  assign tag_o   = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order load responses and ALU/mfc0 results onto
// the single register-file write port and exports a pending-write scoreboard.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = DEF_LD_DEPTH,
  parameter int DW       = DEF_DW
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ld_issue,
  input  logic [4:0]          i_ld_rd,
  output logic                o_ld_full,
  input  logic                i_ld_rvalid,
  input  logic [DW-1:0]       i_ld_rdata,
  output logic                o_ld_rready,
  input  logic                i_alu_valid,
  input  logic [4:0]          i_alu_rd,
  input  logic [DW-1:0]       i_alu_data,
  input  logic                i_mfc0,
  input  logic [DW-1:0]       i_cop0_data,
  output logic                o_alu_ready,
  output logic                o_regWrite,
  output logic [4:0]          o_wrAddr,
  output logic [DW-1:0]       o_wrDataToReg,
  output logic [NUM_REGS-1:0] o_pending,
  output logic                o_err
);
  logic                fifo_full, fifo_empty;
  logic [4:0]          head_tag;
  logic [NUM_REGS-1:0] occ;
  logic                ld_acc, alu_acc, push;

  logic                we_q, we_d;
  logic [4:0]          addr_q, addr_d;
  logic [DW-1:0]       data_q, data_d;
  logic                err_q, err_d;

  assign ld_acc  = i_ld_rvalid & ~fifo_empty;
  assign alu_acc = i_alu_valid & ~ld_acc;
  // A full FIFO can still take a tag when the head leaves in the same cycle.
  assign push    = i_ld_issue & (~fifo_full | ld_acc);

  wb_tag_fifo #(.DEPTH(LD_DEPTH)) u_tag_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .pop_i   (ld_acc),
    .tag_i   (i_ld_rd),
    .tag_o   (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .occ_o   (occ)
  );

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    err_d  = err_q | (i_ld_issue & fifo_full & ~ld_acc) | (i_ld_rvalid & fifo_empty);
    if (ld_acc) begin
      we_d   = (head_tag != REG_ZERO);
      addr_d = head_tag;
      data_d = i_ld_rdata;
    end else if (alu_acc) begin
      we_d   = (i_alu_rd != REG_ZERO);
      addr_d = i_alu_rd;
      data_d = i_mfc0 ? i_cop0_data : i_alu_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q   <= 1'b0;
      addr_q <= REG_ZERO;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign o_ld_full     = fifo_full;
  assign o_ld_rready   = ~fifo_empty;
  assign o_alu_ready   = ~ld_acc;
  assign o_regWrite    = we_q;
  assign o_wrAddr      = addr_q;
  assign o_wrDataToReg = data_q;
  assign o_err         = err_q;
  assign o_pending     = (occ | (we_q ? reg_onehot(addr_q) : '0))
                         & {{(NUM_REGS-1){1'b1}}, 1'b0};
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter: one vector per clock, outputs sampled
// just after the falling edge, before the inputs of that vector are clocked in.
module tb_wb_arbiter;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_ld_issue = 1'b0;
  logic [4:0]  i_ld_rd = '0;
  logic        o_ld_full;
  logic        i_ld_rvalid = 1'b0;
  logic [31:0] i_ld_rdata = '0;
  logic        o_ld_rready;
  logic        i_alu_valid = 1'b0;
  logic [4:0]  i_alu_rd = '0;
  logic [31:0] i_alu_data = '0;
  logic        i_mfc0 = 1'b0;
  logic [31:0] i_cop0_data = '0;
  logic        o_alu_ready;
  logic        o_regWrite;
  logic [4:0]  o_wrAddr;
  logic [31:0] o_wrDataToReg;
  logic [31:0] o_pending;
  logic        o_err;

  always #5 i_clk = ~i_clk;

  wb_arbiter #(.LD_DEPTH(4), .DW(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ld_issue(i_ld_issue), .i_ld_rd(i_ld_rd), .o_ld_full(o_ld_full),
    .i_ld_rvalid(i_ld_rvalid), .i_ld_rdata(i_ld_rdata), .o_ld_rready(o_ld_rready),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_mfc0(i_mfc0), .i_cop0_data(i_cop0_data), .o_alu_ready(o_alu_ready),
    .o_regWrite(o_regWrite), .o_wrAddr(o_wrAddr), .o_wrDataToReg(o_wrDataToReg),
    .o_pending(o_pending), .o_err(o_err)
  );

  typedef struct {
    bit        iss;  bit [4:0] ird;
    bit        rv;   bit [31:0] rdat;
    bit        av;   bit [4:0] ard; bit [31:0] adat;
    bit        mfc0; bit [31:0] cop;
    bit [73:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  function automatic vec_t v(bit iss, bit [4:0] ird, bit rv, bit [31:0] rdat,
                             bit av, bit [4:0] ard, bit [31:0] adat, bit mfc0, bit [31:0] cop,
                             bit full, bit rr, bit ar, bit we, bit [4:0] wa,
                             bit [31:0] wd, bit [31:0] pend, bit err);
    vec_t r;
    r.iss = iss; r.ird = ird; r.rv = rv; r.rdat = rdat;
    r.av = av; r.ard = ard; r.adat = adat; r.mfc0 = mfc0; r.cop = cop;
    r.exp = {full, rr, ar, we, wa, wd, pend, err};
    return r;
  endfunction

  function automatic logic [73:0] actual();
    return {o_ld_full, o_ld_rready, o_alu_ready, o_regWrite, o_wrAddr,
            o_wrDataToReg, o_pending, o_err};
  endfunction

  task automatic chk(input string name, input logic [73:0] exp);
    logic [73:0] act;
    act = actual();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got full/rr/ar/we=%b addr=%0d data=%h pend=%h err=%b, want full/rr/ar/we=%b addr=%0d data=%h pend=%h err=%b",
               name, act[73:70], act[69:65], act[64:33], act[32:1], act[0],
               exp[73:70], exp[69:65], exp[64:33], exp[32:1], exp[0]);
    end
  endtask

  task automatic drive_idle();
    i_ld_issue = 1'b0; i_ld_rd = '0; i_ld_rvalid = 1'b0; i_ld_rdata = '0;
    i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_data = '0; i_mfc0 = 1'b0; i_cop0_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    //         iss ird rv rdat    av ard adat     mf cop      | full rr ar we wa wd       pend      err
    tbl.push_back(v(0, 0, 0, 0,      0, 0, 0,       0, 0,       0, 0, 1, 0, 0, 0,       0,        0)); // 0 idle
    tbl.push_back(v(0, 0, 0, 0,      1, 5, 'h1234,  0, 0,       0, 0, 1, 0, 0, 0,       0,        0)); // 1
    tbl.push_back(v(0, 0, 0, 0,      1, 6, 'h1111,  1, 'hCAFE,  0, 0, 1, 1, 5, 'h1234,  'h20,     0)); // 2
    tbl.push_back(v(0, 0, 0, 0,      0, 0, 0,       0, 0,       0, 0, 1, 1, 6, 'hCAFE,  'h40,     0)); // 3
    tbl.push_back(v(1, 3, 0, 0,      0, 0, 0,       0, 0,       0, 0, 1, 0, 6, 'hCAFE,  0,        0)); // 4
    tbl.push_back(v(1, 7, 0, 0,      0, 0, 0,       0, 0,       0, 1, 1, 0, 6, 'hCAFE,  'h8,      0)); // 5
    tbl.push_back(v(1, 3, 0, 0,      0, 0, 0,       0, 0,       0, 1, 1, 0, 6, 'hCAFE,  'h88,     0)); // 6
    tbl.push_back(v(1, 9, 0, 0,      0, 0, 0,       0, 0,       0, 1, 1, 0, 6, 'hCAFE,  'h88,     0)); // 7
    tbl.push_back(v(0, 0, 0, 0,      0, 0, 0,       0, 0,       1, 1, 1, 0, 6, 'hCAFE,  'h288,    0)); // 8 full
    tbl.push_back(v(0, 0, 1, 'hA,    0, 0, 0,       0, 0,       1, 1, 0, 0, 6, 'hCAFE,  'h288,    0)); // 9
    tbl.push_back(v(0, 0, 1, 'hB,    0, 0, 0,       0, 0,       0, 1, 0, 1, 3, 'hA,     'h288,    0)); // 10
    tbl.push_back(v(0, 0, 1, 'hC,    0, 0, 0,       0, 0,       0, 1, 0, 1, 7, 'hB,     'h288,    0)); // 11
    tbl.push_back(v(0, 0, 1, 'hD,    0, 0, 0,       0, 0,       0, 1, 0, 1, 3, 'hC,     'h208,    0)); // 12
    tbl.push_back(v(0, 0, 0, 0,      0, 0, 0,       0, 0,       0, 0, 1, 1, 9, 'hD,     'h200,    0)); // 13
    tbl.push_back(v(1, 4, 0, 0,      0, 0, 0,       0, 0,       0, 0, 1, 0, 9, 'hD,     0,        0)); // 14
    tbl.push_back(v(0, 0, 1, 'h55,   1, 8, 'h88,    0, 0,       0, 1, 0, 0, 9, 'hD,     'h10,     0)); // 15 load beats alu
    tbl.push_back(v(0, 0, 0, 0,      1, 8, 'h88,    0, 0,       0, 0, 1, 1, 4, 'h55,    'h10,     0)); // 16 alu held
    tbl.push_back(v(0, 0, 0, 0,      1, 0, 'h77,    0, 0,       0, 0, 1, 1, 8, 'h88,    'h100,    0)); // 17 alu r0
    tbl.push_back(v(1, 0, 0, 0,      0, 0, 0,       0, 0,       0, 0, 1, 0, 0, 'h77,    0,        0)); // 18 load r0
    tbl.push_back(v(0, 0, 1, 'h66,   0, 0, 0,       0, 0,       0, 1, 0, 0, 0, 'h77,    0,        0)); // 19
    tbl.push_back(v(0, 0, 0, 0,      0, 0, 0,       0, 0,       0, 0, 1, 0, 0, 'h66,    0,        0)); // 20
    tbl.push_back(v(1, 1, 0, 0,      0, 0, 0,       0, 0,       0, 0, 1, 0, 0, 'h66,    0,        0)); // 21
    tbl.push_back(v(1, 2, 0, 0,      0, 0, 0,       0, 0,       0, 1, 1, 0, 0, 'h66,    'h2,      0)); // 22
    tbl.push_back(v(1, 10, 0, 0,     0, 0, 0,       0, 0,       0, 1, 1, 0, 0, 'h66,    'h6,      0)); // 23
    tbl.push_back(v(1, 11, 0, 0,     0, 0, 0,       0, 0,       0, 1, 1, 0, 0, 'h66,    'h406,    0)); // 24
    tbl.push_back(v(1, 12, 1, 'hE1,  0, 0, 0,       0, 0,       1, 1, 0, 0, 0, 'h66,    'hC06,    0)); // 25 full push+pop
    tbl.push_back(v(0, 0, 0, 0,      0, 0, 0,       0, 0,       1, 1, 1, 1, 1, 'hE1,    'h1C06,   0)); // 26
    tbl.push_back(v(1, 13, 0, 0,     0, 0, 0,       0, 0,       1, 1, 1, 0, 1, 'hE1,    'h1C04,   0)); // 27 drop
    tbl.push_back(v(0, 0, 0, 0,      0, 0, 0,       0, 0,       1, 1, 1, 0, 1, 'hE1,    'h1C04,   1)); // 28
    tbl.push_back(v(0, 0, 1, 'hF1,   0, 0, 0,       0, 0,       1, 1, 0, 0, 1, 'hE1,    'h1C04,   1)); // 29

    drive_idle();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (tbl[k]) begin
      i_ld_issue = tbl[k].iss;  i_ld_rd = tbl[k].ird;
      i_ld_rvalid = tbl[k].rv;  i_ld_rdata = tbl[k].rdat;
      i_alu_valid = tbl[k].av;  i_alu_rd = tbl[k].ard; i_alu_data = tbl[k].adat;
      i_mfc0 = tbl[k].mfc0;     i_cop0_data = tbl[k].cop;
      #1;
      chk($sformatf("vec%0d", k), tbl[k].exp);
      @(negedge i_clk);
    end

    // FIFO now holds 10,11,12 and the write of (2,F1) is on the port.
    drive_idle();
    #1;
    chk("pre_reset", {1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'hF1, 32'h1C04, 1'b1});
    #1 i_rst_n = 1'b0;
    #1;
    chk("reset_async", {1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0});
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ld_rvalid = 1'b1; i_ld_rdata = 32'h99;
    #1;
    chk("resp_empty_rready", {1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0});
    @(negedge i_clk);
    drive_idle();
    #1;
    chk("err_resp_empty", {1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1});
    for (int j = 0; j < 3; j++) begin
      @(negedge i_clk);
      #1;
      chk($sformatf("no_write_after_reset%0d", j),
          {1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
